collision_probe: RTL
====================

Name: collision_probe

Overview:
- Read-side counterpart of the runner's pixel-draw datapath. That datapath writes sprite and floor pixels into the framebuffer; this block reads them back.
- On `start`, it scans the runner's sprite bounding box through the framebuffer read port.
- It reports whether any pixel in the box holds the obstacle colour.
- The game-control FSM uses the result to decide death before it erases and redraws the man.

Parameters:
- OBST_COLOR, 3'b100, colour code that counts as an obstacle.
- RD_LAT, 1, framebuffer read latency in cycles, from `rd_en` to `rd_color` valid. Legal range 1..4.
- X_MAX, 159, last legal screen column.
- Y_MAX, 119, last legal screen row.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a probe; sampled only in IDLE
- x_in  in  8  sprite origin column (top-left)
- y_in  in  7  sprite origin row (top-left)
- man_style  in  1  1 = normal (standing) box, 0 = crouch box
- rd_en  out  1  framebuffer read strobe
- rd_x  out  8  read column
- rd_y  out  7  read row
- rd_color  in  3  read data, valid RD_LAT cycles after `rd_en`
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse when the result is valid
- hit  out  1  obstacle found; held until the next accepted `start`
- hit_x  out  8  column of the first hit in row-major order
- hit_y  out  7  row of the first hit in row-major order

Behaviour:
- Reset is `reset_n`, asynchronous, active-low; clock is `clk`.
- Reset values: FSM = IDLE; `rd_en`, `rd_x`, `rd_y`, `busy`, `done`, `hit`, `hit_x`, `hit_y` all 0; read-tracking pipeline cleared.
- Scan boxes, as offsets from the origin:
  - Normal: columns 0..6, rows 0..6, N = 49 slots.
  - Crouch: columns 1..6, rows 3..6, N = 24 slots.
  - Order is row-major: column increments fastest, then row.
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - On `start` = 1: latch `x_in`, `y_in`, `man_style`; clear `hit`, `hit_x`, `hit_y`; go to SCAN.
  - `start` in any other state is ignored.
- SCAN:
  - Exactly one slot per cycle for N cycles.
  - Absolute coordinates are computed 9 bits wide (x) and 8 bits wide (y) with no truncation.
  - If x > X_MAX or y > Y_MAX, the slot is clipped: `rd_en` = 0 for that cycle, the slot still consumes the cycle, and it is treated as a non-hit.
  - Otherwise `rd_en` = 1 and `rd_x`/`rd_y` = the truncated coordinates.
  - After the last slot, go to DRAIN.
- Read pipeline:
  - An RD_LAT-deep shift register carries a valid flag plus x/y for each slot.
  - When a returning valid entry has `rd_color` == OBST_COLOR and `hit` == 0: set `hit` = 1 and load `hit_x`/`hit_y` from that entry.
  - Later hits do not overwrite the first.
- DRAIN: hold for RD_LAT cycles with `rd_en` = 0, then go to REPORT.
- REPORT: `done` = 1 for exactly one cycle; `busy` = 0; return to IDLE. `start` may be accepted again the following cycle.
- Fixed latency: with `start` sampled at edge 0, `done` is high in cycle N + RD_LAT + 1. With RD_LAT = 1 this is cycle 51 for normal and cycle 26 for crouch, independent of clipping and hit position.
- `busy` is high through SCAN and DRAIN.
- Reset asserted mid-scan: immediate return to IDLE with all outputs at reset values. Data returning after reset is discarded.
- `rd_x`/`rd_y` are don't-care when `rd_en` = 0 but hold their last value. This keeps the mux toggle-free.

Optional Feature:
- Macro: COLLISION_EARLY_EXIT_EN.
- Defined: on the first hit, the FSM leaves SCAN/DRAIN at once and goes to REPORT the next cycle. Remaining reads are not issued, and in-flight reads are discarded (`hit` stays at the first value). Latency then varies; with no hit, the fixed latency above still applies.
- Undefined: always the full fixed-latency scan as above.

Test Plan:
- Normal, origin (30,108), framebuffer all 3'b000 → 49 `rd_en` pulses; `done` in cycle 51; `hit` = 0; `busy` low the same cycle.
- Normal, origin (30,108), obstacle pixels at (33,110) and (35,112) → `hit` = 1, `hit_x` = 33, `hit_y` = 110; `done` in cycle 51 (macro off).
- Crouch, origin (30,108), obstacle at (30,108) only → 24 reads, first at (31,111); `hit` = 0; `done` in cycle 26.
- Normal, origin (157,116), no obstacles → clipped columns 160..162 and rows 120..122 give 3 x 4 = 12 `rd_en` pulses; `done` still in cycle 51.
- `start` pulsed again in cycle 10 of a scan, then reset_n = 0 in cycle 20 → second `start` ignored; after reset, all outputs are 0 and no `done` appears; a new `start` then works normally.
- COLLISION_EARLY_EXIT_EN, RD_LAT = 2, obstacle at offset (0,0) → `done` in cycle 4, `hit_x` = 30, `hit_y` = 108; no `rd_en` after cycle 3.

Source files
------------

// File: rtl/collision_probe.sv
`timescale 1ns/1ps
// collision_probe
//   Reads back the runner's sprite bounding box from the framebuffer and
//   reports whether any pixel in it holds the obstacle colour. The game-control
//   FSM uses the result to decide death before it redraws the man.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  probe request, sampled only in IDLE
//   x_in, y_in, man_style  sprite origin (top-left) and box select (1 = normal)
//   rd_en, rd_x, rd_y      framebuffer read strobe and address
//   rd_color               read data, valid RD_LAT cycles after rd_en
//   busy, done             scan in progress / one-cycle result pulse
//   hit, hit_x, hit_y      first obstacle pixel in row-major order
//   state_dbg_o            current FSM state, for observation only
//
// Handshake: start is a request taken only while IDLE; the cycle after it is
// taken busy rises and stays high until the cycle done pulses, and hit/hit_x/
// hit_y are valid from that done cycle until the next accepted start.
//
// Build option
//   COLLISION_EARLY_EXIT_EN  when defined, the first hit ends the probe at once
//                            (pending reads are dropped); otherwise every probe
//                            takes the full fixed latency N + RD_LAT + 1.
module collision_probe #(
  parameter logic [2:0] OBST_COLOR = 3'b100,
  parameter int         RD_LAT     = 1,
  parameter int         X_MAX      = 159,
  parameter int         Y_MAX      = 119
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic       man_style,
  output logic       rd_en,
  output logic [7:0] rd_x,
  output logic [6:0] rd_y,
  input  logic [2:0] rd_color,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [7:0] hit_x,
  output logic [6:0] hit_y,
  output logic [1:0] state_dbg_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] org_x_q, org_x_d;
  logic [6:0] org_y_q, org_y_d;
  logic       style_q, style_d;
  logic [2:0] off_x_q, off_x_d;   // offset of the slot currently on rd_x/rd_y
  logic [2:0] off_y_q, off_y_d;
  logic [2:0] drain_q, drain_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_x_q, rd_x_d;
  logic [6:0] rd_y_q, rd_y_d;
  logic       hit_q, hit_d;
  logic [7:0] hit_x_q, hit_x_d;
  logic [6:0] hit_y_q, hit_y_d;

  // Read-tracking pipeline: entry RD_LAT-1 lines up with rd_color.
  logic       pipe_v_q [RD_LAT];
  logic [7:0] pipe_x_q [RD_LAT];
  logic [6:0] pipe_y_q [RD_LAT];

  logic       issue;
  logic       flush;
  logic       new_hit;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] sel_off_x, sel_off_y;
  logic [2:0] nxt_off_x, nxt_off_y;
  logic [8:0] abs_x;
  logic [7:0] abs_y;
  logic       in_range;
  logic       last_slot;

  // Both boxes end on offset (6,6), so the last slot needs no counter.
  assign last_slot = (off_x_q == 3'd6) && (off_y_q == 3'd6);

  assign new_hit = pipe_v_q[RD_LAT-1] && (rd_color == OBST_COLOR) && !hit_q &&
                   ((state_q == S_SCAN) || (state_q == S_DRAIN));

  // The read address register is loaded one edge ahead: on start it takes
  // slot 0 from the live inputs, during SCAN it takes the following slot.
  always_comb begin
    nxt_off_x = off_x_q + 3'd1;
    nxt_off_y = off_y_q;
    if (off_x_q == 3'd6) begin
      nxt_off_x = style_q ? 3'd0 : 3'd1;
      nxt_off_y = off_y_q + 3'd1;
    end
    if (state_q == S_IDLE) begin
      base_x    = x_in;
      base_y    = y_in;
      sel_off_x = man_style ? 3'd0 : 3'd1;
      sel_off_y = man_style ? 3'd0 : 3'd3;
    end else begin
      base_x    = org_x_q;
      base_y    = org_y_q;
      sel_off_x = nxt_off_x;
      sel_off_y = nxt_off_y;
    end
    abs_x    = {1'b0, base_x} + {6'd0, sel_off_x};
    abs_y    = {1'b0, base_y} + {5'd0, sel_off_y};
    in_range = (abs_x <= 9'(X_MAX)) && (abs_y <= 8'(Y_MAX));
  end

  always_comb begin
    state_d = state_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    style_d = style_q;
    off_x_d = off_x_q;
    off_y_d = off_y_q;
    drain_d = drain_q;
    rd_en_d = 1'b0;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    hit_d   = hit_q;
    hit_x_d = hit_x_q;
    hit_y_d = hit_y_q;
    issue   = 1'b0;
    flush   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          org_x_d = x_in;
          org_y_d = y_in;
          style_d = man_style;
          off_x_d = sel_off_x;
          off_y_d = sel_off_y;
          hit_d   = 1'b0;
          hit_x_d = 8'd0;
          hit_y_d = 7'd0;
          issue   = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (last_slot) begin
          drain_d = 3'd0;
          state_d = S_DRAIN;
        end else begin
          off_x_d = sel_off_x;
          off_y_d = sel_off_y;
          issue   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 3'(RD_LAT - 1)) state_d = S_REPORT;
        else                           drain_d = drain_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Clipped slots still use their cycle but issue no read; the address
    // register holds so the read mux does not toggle.
    if (issue && in_range) begin
      rd_en_d = 1'b1;
      rd_x_d  = abs_x[7:0];
      rd_y_d  = abs_y[6:0];
    end

    if (new_hit) begin
      hit_d   = 1'b1;
      hit_x_d = pipe_x_q[RD_LAT-1];
      hit_y_d = pipe_y_q[RD_LAT-1];
`ifdef COLLISION_EARLY_EXIT_EN
      state_d = S_REPORT;
      rd_en_d = 1'b0;
      flush   = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      org_x_q <= 8'd0;
      org_y_q <= 7'd0;
      style_q <= 1'b0;
      off_x_q <= 3'd0;
      off_y_q <= 3'd0;
      drain_q <= 3'd0;
      rd_en_q <= 1'b0;
      rd_x_q  <= 8'd0;
      rd_y_q  <= 7'd0;
      hit_q   <= 1'b0;
      hit_x_q <= 8'd0;
      hit_y_q <= 7'd0;
    end else begin
      state_q <= state_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      style_q <= style_d;
      off_x_q <= off_x_d;
      off_y_q <= off_y_d;
      drain_q <= drain_d;
      rd_en_q <= rd_en_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      hit_q   <= hit_d;
      hit_x_q <= hit_x_d;
      hit_y_q <= hit_y_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_x_q[i] <= 8'd0;
        pipe_y_q[i] <= 7'd0;
      end
    end else begin
      pipe_v_q[0] <= rd_en_q && !flush;
      pipe_x_q[0] <= rd_x_q;
      pipe_y_q[0] <= rd_y_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1] && !flush;
        pipe_x_q[i] <= pipe_x_q[i-1];
        pipe_y_q[i] <= pipe_y_q[i-1];
      end
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign busy        = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done        = (state_q == S_REPORT);
  assign hit         = hit_q;
  assign hit_x       = hit_x_q;
  assign hit_y       = hit_y_q;
  assign state_dbg_o = state_q;

endmodule
